// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture engine: ring-buffered sampling with a mask/value trigger,
// a programmable pre-trigger window and a valid/ready byte readout of the capture.
module la_capture_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sample_en,
    input  logic [WIDTH-1:0]      probe_in,
    input  logic [WIDTH-1:0]      trig_mask,
    input  logic [WIDTH-1:0]      trig_value,
    input  logic [DEPTH_LOG2-1:0] pretrig,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic                  done
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] addr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READ} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sync_q, ps_q;
    addr_t              wp_q, wp_d, pt_q, pt_d, count_q, count_d;
    addr_t              taddr_q, taddr_d, post_q, post_d, rp_q, rp_d;
    cnt_t               iss_q, iss_d, xfer_q, xfer_d;
    logic               trig_q, trig_d, done_q, done_d;
    logic               rv_q, rv_d, mv_q, mv_d;
    logic [WIDTH-1:0]   rdat_q, rdat_d;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [WIDTH-1:0]   mem_q;
    logic               match, we, re, out_load, xfer;

    assign match    = ((ps_q ^ trig_value) & trig_mask) == '0;
    assign we       = sample_en && !abort &&
                      (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST);
    // mem_q is the prefetch stage: refilled whenever it is empty or drains into the output register
    assign out_load = !rv_q || rd_ready;
    assign re       = (state_q == S_READ) && (!mv_q || out_load);
    assign xfer     = rv_q && rd_ready;

    always_ff @(posedge clk) begin
        if (we) mem[wp_q] <= ps_q;
        if (re) mem_q <= mem[rp_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            ps_q    <= '0;
            wp_q    <= '0;
            pt_q    <= '0;
            count_q <= '0;
            taddr_q <= '0;
            post_q  <= '0;
            rp_q    <= '0;
            iss_q   <= '0;
            xfer_q  <= '0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
            mv_q    <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= probe_in;
            ps_q    <= sync_q;
            wp_q    <= wp_d;
            pt_q    <= pt_d;
            count_q <= count_d;
            taddr_q <= taddr_d;
            post_q  <= post_d;
            rp_q    <= rp_d;
            iss_q   <= iss_d;
            xfer_q  <= xfer_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            rv_q    <= rv_d;
            mv_q    <= mv_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        pt_d    = pt_q;
        count_d = count_q;
        taddr_d = taddr_q;
        post_d  = post_q;
        rp_d    = rp_q;
        iss_d   = iss_q;
        xfer_d  = xfer_q;
        trig_d  = trig_q;
        done_d  = 1'b0;
        rv_d    = rv_q;
        mv_d    = mv_q;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    pt_d    = pretrig;
                    wp_d    = '0;
                    count_d = '0;
                    trig_d  = 1'b0;
                    state_d = (pretrig == '0) ? S_WAIT : S_PRE;
                end
            end
            S_PRE: begin
                if (sample_en) begin
                    wp_d    = wp_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == pt_q) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sample_en) begin
                    wp_d = wp_q + 1'b1;
                    if (match) begin
                        taddr_d = wp_q;
                        trig_d  = 1'b1;
                        post_d  = ~pt_q;   // DEPTH - pt - 1
                        if (post_d == '0) begin
                            state_d = S_READ;
                            rp_d    = wp_q - pt_q;
                            iss_d   = cnt_t'(DEPTH);
                            xfer_d  = '0;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                if (sample_en) begin
                    wp_d   = wp_q + 1'b1;
                    post_d = post_q - 1'b1;
                    if (post_d == '0) begin
                        state_d = S_READ;
                        rp_d    = taddr_q - pt_q;
                        iss_d   = cnt_t'(DEPTH);
                        xfer_d  = '0;
                    end
                end
            end
            S_READ: begin
                if (re) begin
                    mv_d = (iss_q != '0);
                    if (iss_q != '0) begin
                        rp_d  = rp_q + 1'b1;
                        iss_d = iss_q - 1'b1;
                    end
                end
                if (out_load) begin
                    rv_d = mv_q;
                    if (mv_q) rdat_d = mem_q;
                end
                if (xfer) begin
                    xfer_d = xfer_q + 1'b1;
                    if (xfer_q == cnt_t'(DEPTH - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        rv_d    = 1'b0;
                        mv_d    = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            rv_d    = 1'b0;
            mv_d    = 1'b0;
            trig_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:         state = 2'd0;
            S_PRE:          state = 2'd1;
            S_WAIT, S_POST: state = 2'd2;
            default:        state = 2'd3;
        endcase
    end

    assign rd_data   = rdat_q;
    assign rd_valid  = rv_q;
    assign triggered = trig_q;
    assign done      = done_q;
endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- Capture engine of the logic analyzer. Samples the 8 probe channels into an on-chip ring buffer and detects a mask/value trigger.
- Retains a programmable number of pre-trigger samples and fills the rest of the buffer post-trigger.
- Streams the finished capture out as bytes over a valid/ready handshake. That byte stream is the data input of the downstream 8-bit output mux, which selects between capture data and status bytes.

Parameters:
- DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2 samples.
- WIDTH, 8, probe/sample width; fixed at 8 to match the downstream mux.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  1-cycle pulse; starts a capture; honoured only in IDLE.
- abort  in  1  level; forces IDLE from any state.
- sample_en  in  1  sample strobe from the rate divider; one sample is taken per cycle in which it is high.
- probe_in  in  WIDTH  raw asynchronous probe pins.
- trig_mask  in  WIDTH  1 = channel participates in the trigger.
- trig_value  in  WIDTH  required level for each masked channel.
- pretrig  in  DEPTH_LOG2  number of samples to keep before the trigger; sampled at arm.
- rd_data  out  WIDTH  readout byte.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts the byte.
- state  out  2  0 IDLE, 1 PRETRIG, 2 WAIT_TRIG/POST (busy), 3 READOUT.
- triggered  out  1  sticky; set when the trigger fires, cleared by arm or abort.
- done  out  1  1-cycle pulse when the last byte is accepted.

Behaviour:
- Reset values: state IDLE, all pointers and counters 0, rd_data 0, rd_valid 0, triggered 0, done 0.
- Synchroniser: probe_in passes through a 2-flop synchroniser. The resulting signal ps is what is stored and what is compared.
- Trigger match: match = (((ps ^ trig_value) & trig_mask) == 0). It is evaluated only on cycles with sample_en. trig_mask = 0 fires on the first WAIT_TRIG sample.
- Sample write: on sample_en in PRETRIG, WAIT_TRIG or POST, write ps to mem[wp] and increment wp modulo DEPTH (wrap-around is required).
- IDLE:
  - On arm: latch pretrig into pt, clear wp, count and triggered.
  - If pt == 0 go to WAIT_TRIG, else go to PRETRIG.
- PRETRIG:
  - Each sample increments count.
  - When count reaches pt, go to WAIT_TRIG on the same edge.
  - Samples that match during PRETRIG do not trigger.
- WAIT_TRIG:
  - Keep writing samples; older samples are overwritten in the ring.
  - On a matching sample: write it, record taddr = wp, set triggered, load post = DEPTH - pt - 1, go to POST.
  - If post = 0, go straight to READOUT.
- POST:
  - Each sample decrements post.
  - When it reaches 0 after the write, go to READOUT.
  - Start address for readout is rp = taddr - pt, modulo DEPTH.
- READOUT:
  - Memory read latency is 1 cycle. rd_valid rises 2 cycles after entry.
  - rd_data and rd_valid are held stable while rd_valid && !rd_ready.
  - A transfer occurs when rd_valid && rd_ready. Back-to-back transfers at 1 byte/cycle must be sustained with rd_ready held high; use a prefetch/skid register.
  - Exactly DEPTH bytes are emitted, oldest first. The trigger sample is byte index pt.
  - After the DEPTH-th transfer: rd_valid goes low on the next edge, done pulses, state goes to IDLE.
- sample_en during READOUT or IDLE is ignored. The buffer is never written outside a capture.
- abort:
  - Highest priority. Next edge: IDLE, rd_valid 0, triggered 0, no done pulse.
  - arm in the same cycle as abort is ignored.
- arm outside IDLE is ignored.
- rst mid-operation: immediate return to reset values. Memory contents are don't-care.
- Timing: trigger fire to first rd_valid = post sample strobes + 2 clocks.

Test Plan (DEPTH_LOG2=4, DEPTH=16, sample_en=1 unless stated):
- Basic pre/post capture:
  - Stimulus: probe_in counts 0,1,2,…; pt=4; mask=FF; value=0x20; arm.
  - Response: triggered set when 0x20 is sampled; 16 bytes read 0x1C..0x2B; done pulses once; state returns to 0.
- Immediate trigger:
  - Stimulus: pt=0, mask=00.
  - Response: first sample triggers; readout is the 16 consecutive samples starting at the first one after arm plus synchroniser delay.
- Ring wrap:
  - Stimulus: pt=3; trigger arrives 40 samples after PRETRIG completes.
  - Response: bytes 0..2 are the 3 samples preceding the trigger, byte 3 is the trigger value, no stale data appears.
- Backpressure:
  - Stimulus: toggle rd_ready randomly during readout.
  - Response: rd_data is stable whenever stalled; no byte is lost or duplicated; exactly 16 transfers; with rd_ready held high, one transfer per cycle.
- Gated sampling:
  - Stimulus: sample_en every 3rd cycle.
  - Response: only strobed samples are stored; a match on an unstrobed cycle does not trigger.
- Abort/reset:
  - Stimulus: abort in WAIT_TRIG and again mid-READOUT; rst asserted during POST.
  - Response: IDLE on the next edge (asynchronous for rst); rd_valid=0, triggered=0, no done; a new arm then completes normally.
